lfsr_chain: RTL and testbench

//   Long cascaded shift-register/LFSR chain used as a simulator and synthesis sizing load.
//   - Built from N_STAGES identical stages.
//   - Each stage is a 10-flop shift register with an XNOR feedback tap.
//   - Stage k output drives stage k+1 input; serial in at d, serial out at q.
//   - Default size is 1000 stages = 10,000 flops plus 1000 XNORs, roughly 100k equivalent gates.
//   - Sits standalone under a bench; the bench may loop q back to d externally.

---
 rtl/lfsr_chain_pkg.sv | 10 +
 rtl/lfsr_chain_stage.sv | 39 +++
 rtl/lfsr_chain.sv | 37 +++
 tb/tb_lfsr_chain.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_chain_pkg.sv
// rtl/lfsr_chain_pkg.sv - default sizing constants for the cascaded LFSR chain
package lfsr_chain_pkg;

  // 1000 stages of 10 flops: the standard sizing load
  localparam int DEFAULT_N_STAGES  = 1000;
  localparam int DEFAULT_STAGE_LEN = 10;
  // 1-based position of the in-stage flop that feeds the XNOR
  localparam int DEFAULT_TAP_POS   = 7;

endpackage

// File: rtl/lfsr_chain_stage.sv
// rtl/lfsr_chain_stage.sv - one shift-register stage with XNOR feedback into its first flop
module lfsr_chain_stage
  import lfsr_chain_pkg::*;
#(
  parameter int STAGE_LEN = DEFAULT_STAGE_LEN,
  parameter int TAP_POS   = DEFAULT_TAP_POS
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  // r_bits[0] is b[1], r_bits[STAGE_LEN-1] is b[STAGE_LEN]
  logic [STAGE_LEN-1:0] r_bits;
  logic                 w_fb;

  // XNOR keeps the all-zero reset state from being a lock-up state
  assign w_fb = ~(din ^ r_bits[TAP_POS-1]);

  generate
    if (STAGE_LEN == 1) begin : g_single
      // Single-flop stage: the flop is both head and tail
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_bits <= '0;
        else       r_bits <= w_fb;
      end
    end else begin : g_multi
      // Shift towards the tail, feedback enters at the head
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_bits <= '0;
        else       r_bits <= {r_bits[STAGE_LEN-2:0], w_fb};
      end
    end
  endgenerate

  assign dout = r_bits[STAGE_LEN-1];

endmodule

// File: rtl/lfsr_chain.sv
// rtl/lfsr_chain.sv - N_STAGES cascaded LFSR stages, serial in at d, serial out at q
module lfsr_chain
  import lfsr_chain_pkg::*;
#(
  parameter int N_STAGES  = DEFAULT_N_STAGES,
  parameter int STAGE_LEN = DEFAULT_STAGE_LEN,
  parameter int TAP_POS   = DEFAULT_TAP_POS
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  // w_link[k] is the input of stage k; w_link[N_STAGES] is the chain tail
  logic [N_STAGES:0] w_link;

  assign w_link[0] = d;

  generate
    for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
      lfsr_chain_stage #(
        .STAGE_LEN (STAGE_LEN),
        .TAP_POS   (TAP_POS)
      ) u_stage (
        .clk   (clk),
        .reset (reset),
        .din   (w_link[g]),
        .dout  (w_link[g+1])
      );
    end
  endgenerate

  // q is the last stage's tail flop, so there is no combinational d-to-q path
  assign q = w_link[N_STAGES];

endmodule

// File: tb/tb_lfsr_chain.sv
// tb/tb_lfsr_chain.sv - self-checking bench for lfsr_chain
module tb_lfsr_chain;

  localparam int L     = 10;
  localparam int TAP   = 7;
  localparam int NBIG  = 1000;
  localparam int TMAX  = 1200;

  typedef struct packed {
    logic d;
    logic exp_q;
  } vec_t;

  logic clk   = 1'b0;
  logic clk_b = 1'b0;
  always #5  clk   = ~clk;
  always #50 clk_b = ~clk_b;

  logic r1 = 1'b1, d1 = 1'b0, q1;
  logic r2 = 1'b1, d2 = 1'b0, q2;
  logic rb = 1'b1, db = 1'b0, qb;
  logic rl = 1'b1, ql;

  int vectors = 0;
  int miscompares = 0;

  lfsr_chain #(.N_STAGES(1)) u_n1 (.clk(clk), .reset(r1), .d(d1), .q(q1));
  lfsr_chain #(.N_STAGES(2)) u_n2 (.clk(clk), .reset(r2), .d(d2), .q(q2));
  lfsr_chain                 u_big (.clk(clk), .reset(rb), .d(db), .q(qb));
  lfsr_chain                 u_loop (.clk(clk_b), .reset(rl), .d(ql), .q(ql));

  // Reference model as time sequences: hx[s][t] is b[1] of stage s after edge t.
  // x_s(t) = ~(in_s(t-1) ^ x_s(t-TAP)); stage output after edge t is x_s(t-(L-1)).
  bit hx [0:NBIG-1][0:TMAX];

  function automatic bit mget(int s, int t);
    if (t <= 0) return 1'b0;
    return hx[s][t];
  endfunction

  function automatic void mstep(int n, int t, bit dval);
    for (int s = 0; s < n; s++) begin
      bit inb;
      inb = (s == 0) ? dval : mget(s - 1, t - 1 - (L - 1));
      hx[s][t] = ~(inb ^ mget(s, t - TAP));
    end
  endfunction

  function automatic bit mq(int n, int t);
    return mget(n - 1, t - (L - 1));
  endfunction

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: q=%b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic drive(input int u, input logic rv, input logic dv);
    case (u)
      0: begin r1 = rv; d1 = dv; end
      1: begin r2 = rv; d2 = dv; end
      default: begin rb = rv; db = dv; end
    endcase
  endtask

  function automatic logic qof(input int u);
    case (u)
      0: return q1;
      1: return q2;
      default: return qb;
    endcase
  endfunction

  // Reset pulse spanning one edge, released mid-cycle; next posedge is edge 1
  task automatic do_reset(input int u);
    drive(u, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    drive(u, 1'b0, 1'b0);
  endtask

  // One edge with d=dv, then q compared with the model
  task automatic step(input int u, input int n, input int t, input logic dv, input string name);
    drive(u, 1'b0, dv);
    @(posedge clk);
    #1;
    mstep(n, t, dv);
    chk(name, t, qof(u), mq(n, t));
  endtask

  vec_t vec1 [1:30];
  bit   refq [0:TMAX];

  initial begin
    // Expected q for one stage, d=0 after reset: period-14 square wave delayed by 9 edges
    for (int e = 1; e <= 30; e++) begin
      vec1[e].d     = 1'b0;
      vec1[e].exp_q = (e >= 10 && e <= 16) || (e >= 24 && e <= 30);
    end

    // Reset held from time 0
    #1;
    chk("reset_q1", 0, q1, 1'b0);
    chk("reset_q2", 0, q2, 1'b0);
    chk("reset_qb", 0, qb, 1'b0);
    chk("reset_ql", 0, ql, 1'b0);

    // Test 1: single stage, d=0, table-driven
    do_reset(0);
    for (int e = 1; e <= 30; e++) begin
      drive(0, 1'b0, vec1[e].d);
      @(posedge clk);
      #1;
      chk("t1_d0", e, q1, vec1[e].exp_q);
    end

    // Test 2: single stage, d=1 held, q never leaves 0
    do_reset(0);
    for (int e = 1; e <= 110; e++) begin
      drive(0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      chk("t2_d1", e, q1, 1'b0);
    end

    // Test 3: default chain, d=0; tail self-seeds like a single stage until edge 19
    do_reset(2);
    for (int e = 1; e <= 19; e++) begin
      drive(2, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("t3_big", e, qb, vec1[e].exp_q);
    end

    // Test 4: asynchronous reset mid-run, then recovery from edge 1
    do_reset(0);
    for (int e = 1; e <= 12; e++) begin
      drive(0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("t4_pre", 12, q1, 1'b1);
    drive(0, 1'b1, 1'b0);
    #1;
    chk("t4_async", 0, q1, 1'b0);
    @(posedge clk);
    #1;
    chk("t4_held", 0, q1, 1'b0);
    #1;
    drive(0, 1'b0, 1'b0);
    for (int e = 1; e <= 30; e++) begin
      drive(0, 1'b0, vec1[e].d);
      @(posedge clk);
      #1;
      chk("t4_recover", e, q1, vec1[e].exp_q);
    end

    // Test 5: two stages, one-cycle d pulse sampled at edge 40
    for (int t = 1; t <= 120; t++) begin
      mstep(2, t, 1'b0);
      refq[t] = mq(2, t);
    end
    do_reset(1);
    for (int t = 1; t <= 120; t++) begin
      step(1, 2, t, (t == 40), "t5_model");
      if (t < 59) chk("t5_nodiverge", t, q2, refq[t]);
      if (t == 59) chk("t5_diverge", t, q2, ~refq[t]);
    end

    // Random d with random asynchronous resets, on one- and two-stage chains
    for (int round = 0; round < 6; round++) begin
      int u, n, rst_at, t;
      u = round % 2;
      n = u + 1;
      rst_at = $urandom_range(20, 100);
      do_reset(u);
      t = 0;
      for (int k = 1; k <= 150; k++) begin
        if (k == rst_at) begin
          drive(u, 1'b1, 1'b0);
          #1;
          chk("rnd_async", k, qof(u), 1'b0);
          @(posedge clk);
          #2;
          drive(u, 1'b0, 1'b0);
          t = 0;
        end
        t++;
        step(u, n, t, logic'($urandom_range(0, 1)), "rnd");
      end
    end

    // Test 6: default chain looped back, two identical runs at 100-unit period
    for (int run = 0; run < 2; run++) begin
      rl = 1'b1;
      @(posedge clk_b);
      #20;
      rl = 1'b0;
      for (int t = 1; t <= 1000; t++) begin
        @(posedge clk_b);
        #10;
        mstep(NBIG, t, mq(NBIG, t - 1));
        chk(run == 0 ? "t6_loop_run1" : "t6_loop_run2", t, ql, mq(NBIG, t));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
